// File: rtl/hex_scan_controller_pkg.sv
// Shared constants for the 4-digit hex display: digit geometry and segment codes.
// Segment codes are packed {a,b,c,d,e,f,g}, active-high.
package hex_scan_controller_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int SEG_W      = 7;

    typedef logic [1:0]          digit_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [SEG_W-1:0]    seg_t;

    localparam seg_t SEG_0   = 7'h7E;
    localparam seg_t SEG_1   = 7'h30;
    localparam seg_t SEG_2   = 7'h6D;
    localparam seg_t SEG_3   = 7'h79;
    localparam seg_t SEG_4   = 7'h33;
    localparam seg_t SEG_5   = 7'h5B;
    localparam seg_t SEG_6   = 7'h5F;
    localparam seg_t SEG_7   = 7'h70;
    localparam seg_t SEG_8   = 7'h7F;
    localparam seg_t SEG_9   = 7'h7B;
    localparam seg_t SEG_A   = 7'h77;
    localparam seg_t SEG_B   = 7'h1F;
    localparam seg_t SEG_C   = 7'h4E;
    localparam seg_t SEG_D   = 7'h3D;
    localparam seg_t SEG_E   = 7'h4F;
    localparam seg_t SEG_F   = 7'h47;
    localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/hex_scan_controller_decoder.sv
// Combinational hex nibble to 7-segment decoder; also used by the legacy display driver.
module hex_seg_decoder
    import hex_scan_controller_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    segments
);

    always_comb begin
        segments = SEG_OFF;
        unique case (nibble)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex_scan_controller.sv
// 4-digit 7-segment scan controller: anode multiplexing, frame-synchronous double
// buffering, brightness PWM, blanking, leading-zero suppression and blink.
module hex_scan_controller
    import hex_scan_controller_pkg::*;
#(
    parameter int SCAN_DIV     = 65536,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [3:0]            brightness,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic                  lz_suppress,
    input  logic                  blink_en,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [SEG_W-1:0]      segments,
    output logic                  frame_done
);

    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_ONE   = SLOT_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
    localparam digit_t             DIGIT_LAST = 2'd3;
    localparam digit_t             DIGIT_ONE  = 2'd1;

    logic [SLOT_W-1:0]     slot_cnt;
    digit_t                digit;
    logic [15:0]           active;
    logic [15:0]           pending;
    logic                  pending_valid;
    logic [FRAME_W-1:0]    frame_cnt;
    logic                  blink_phase;

    logic                  slot_tc;
    logic                  frame_bound;
    logic                  xfer;
    logic [NUM_DIGITS-1:0] lz_off;
    nibble_t               cur_nibble;
    seg_t                  cur_seg;
    logic                  lit;

    assign slot_tc     = (slot_cnt == SLOT_LAST);
    assign frame_bound = slot_tc && (digit == DIGIT_LAST);
    assign data_ready  = !pending_valid;
    assign xfer        = data_valid && !pending_valid;

    assign cur_nibble  = active[{digit, 2'b00} +: NIBBLE_W];

    // Digit 0 is never suppressed so an all-zero value still shows "0".
    always_comb begin
        lz_off    = '0;
        lz_off[3] = lz_suppress && (active[15:12] == 4'h0);
        lz_off[2] = lz_suppress && (active[15:8]  == 8'h00);
        lz_off[1] = lz_suppress && (active[15:4]  == 12'h000);
    end

    assign lit = !blank_mask[digit]
              && (slot_cnt[3:0] < brightness)
              && !(blink_en && blink_phase)
              && !lz_off[digit];

    hex_seg_decoder u_seg_decoder (
        .nibble   (cur_nibble),
        .segments (cur_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else begin
            slot_cnt <= slot_cnt + SLOT_ONE;
            if (slot_tc) begin
                digit <= digit + DIGIT_ONE;
            end
        end
    end

    // Pending is only written while empty, so it cannot collide with the frame swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            pending_valid <= 1'b0;
            active        <= '0;
        end else if (frame_bound && pending_valid) begin
            active        <= pending;
            pending_valid <= 1'b0;
        end else if (xfer) begin
            pending       <= data_in;
            pending_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_bound) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FRAME_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodes     <= '0;
            segments   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            anodes     <= lit ? (4'b0001 << digit) : '0;
            segments   <= lit ? cur_seg : SEG_OFF;
            frame_done <= frame_bound;
        end
    end

endmodule

// File: tb/tb_hex_scan_controller.sv
// Randomized bench for hex_scan_controller against a cycle-count based reference model.
module tb_hex_scan_controller;

    localparam int SD = 16;
    localparam int BF = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  brightness;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic        blink_en;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        frame_done;

    hex_scan_controller #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .brightness  (brightness),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .blink_en    (blink_en),
        .anodes      (anodes),
        .segments    (segments),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference state: cycles since reset release plus the two buffers.
    int          m_t;
    bit          m_pv;
    logic [15:0] m_pend;
    logic [15:0] m_act;

    logic [15:0] send_q[$];
    bit          eager;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, m_t, obs, exp);
        end
    endtask

    function automatic logic [15:0] gen_value();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'($urandom_range(0, 255));
            2:       return 16'($urandom) & 16'h0FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_pv   = 0;
        m_pend = '0;
        m_act  = '0;
    endtask

    // One clock: compare outputs produced by the last posedge, advance the model, drive inputs.
    task automatic step();
        int          slot, dig, frames;
        bit          fb, phase, lz, lit, xfer;
        logic [3:0]  nib;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        @(negedge clk);
        slot   = m_t % SD;
        dig    = (m_t / SD) % 4;
        frames = m_t / (4 * SD);
        phase  = ((frames / BF) % 2) == 1;
        fb     = (slot == SD - 1) && (dig == 3);
        nib    = 4'((m_act >> (4 * dig)) & 16'hF);
        lz     = lz_suppress && (dig != 0) && ((m_act >> (4 * dig)) == 0);
        lit    = !blank_mask[dig] && ((slot % 16) < brightness) && !(blink_en && phase) && !lz;
        exp_an  = lit ? 4'(1 << dig) : 4'h0;
        exp_seg = lit ? seg_tab[nib] : 7'h00;
        check_val("anodes", anodes, exp_an);
        check_val("segments", segments, exp_seg);
        check_val("frame_done", frame_done, fb);
        check_val("anodes_onehot0", $onehot0(anodes), 1);

        xfer = data_valid && !m_pv;
        if (fb && m_pv) begin
            m_act = m_pend;
            m_pv  = 0;
        end else if (xfer) begin
            m_pend = data_in;
            m_pv   = 1;
        end
        m_t++;
        check_val("data_ready", data_ready, !m_pv);

        if (xfer) void'(send_q.pop_front());
        if (!(data_valid && !xfer)) begin
            data_valid = (send_q.size() > 0) && (eager || $urandom_range(0, 3) != 0);
            data_in    = data_valid ? send_q[0] : 16'($urandom);
        end
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_anodes", anodes, 0);
        check_val("rst_segments", segments, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_data_ready", data_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int waited;
        rst_n       = 1'b0;
        data_in     = '0;
        data_valid  = 1'b0;
        brightness  = 4'd15;
        blank_mask  = 4'h0;
        lz_suppress = 1'b0;
        blink_en    = 1'b0;
        eager       = 1'b0;
        model_reset();
        #1;
        check_val("init_anodes", anodes, 0);
        check_val("init_segments", segments, 0);
        check_val("init_frame_done", frame_done, 0);
        check_val("init_data_ready", data_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int ph = 0; ph < 30; ph++) begin
            eager = 1'b0;
            case (ph)
                0: send_q.push_back(16'h1A2F);
                1: begin send_q.push_back(16'h1111); send_q.push_back(16'h2222); eager = 1'b1; end
                2: begin lz_suppress = 1'b1; send_q.push_back(16'h0070); send_q.push_back(16'h0000); end
                3: begin lz_suppress = 1'b0; brightness = 4'd4; send_q.push_back(16'h8E3C); end
                4: begin brightness = 4'd0; end
                5: begin brightness = 4'd15; blank_mask = 4'b0101; end
                6: begin blank_mask = 4'h0; blink_en = 1'b1; end
                default: begin
                    brightness  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
                    blank_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                    lz_suppress = 1'($urandom);
                    blink_en    = ($urandom_range(0, 4) == 0);
                    repeat ($urandom_range(0, 3)) send_q.push_back(gen_value());
                end
            endcase

            if (ph == 12 || ph == 24) begin
                send_q.push_back(gen_value());
                send_q.push_back(gen_value());
                eager  = 1'b1;
                waited = 0;
                while (data_ready && waited < 6 * SD) begin
                    step();
                    waited++;
                end
                check_val("ready_low_pre_rst", data_ready, 0);
                apply_reset();
            end

            repeat ($urandom_range(2, 4) * 4 * SD) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
